// File: rtl/regdec_pkg.sv
// Shared types and instruction field positions for the register-read/decode stage.
package regdec_pkg;

  typedef enum logic [1:0] {
    SRC_REG    = 2'b00,
    SRC_DADDR9 = 2'b01,
    SRC_IMM12  = 2'b10,
    SRC_IMM16  = 2'b11
  } alusrc_t;

  localparam int RT_LSB  = 0;
  localparam int RT_MSB  = 4;
  localparam int RN_LSB  = 5;
  localparam int RN_MSB  = 9;
  localparam int RM_LSB  = 16;
  localparam int RM_MSB  = 20;
  localparam int D9_LSB  = 12;
  localparam int D9_MSB  = 20;
  localparam int I12_LSB = 10;
  localparam int I12_MSB = 21;
  localparam int I16_LSB = 5;
  localparam int I16_MSB = 20;

endpackage

// File: rtl/regdec_regfile.sv
// Register file with one write and two combinational reads; the top index is the
// hardwired zero register and has no storage.
module regdec_regfile #(
  parameter int DW   = 64,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  localparam int NENT = NREG - 1;
  localparam logic [AW-1:0] XZR = AW'(NREG - 1);

  logic [DW-1:0] mem_q [NENT];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NENT; i++) mem_q[i] <= '0;
    end else if (we && (waddr < XZR)) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Anything at or above the zero-register index reads as zero.
  always_comb begin
    rdata_a = (raddr_a >= XZR) ? '0 : mem_q[raddr_a];
    rdata_b = (raddr_b >= XZR) ? '0 : mem_q[raddr_b];
  end

endmodule

// File: rtl/regdec_stage.sv
// Register-read/decode stage: operand read with internal forwarding, B-source
// immediate selection, load-use stall detection and the execute-stage registers.
module regdec_stage
  import regdec_pkg::*;
#(
  parameter int DW   = 64,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG),
  parameter int NFWD = 2,
  parameter int CW   = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr_in,
  input  logic               valid_in,
  input  logic [CW-1:0]      ctrl_in,
  input  logic               reg2loc,
  input  logic [1:0]         alusrc,
  input  logic [NFWD-1:0]    fwd_we,
  input  logic [NFWD*AW-1:0] fwd_rd,
  input  logic [NFWD*DW-1:0] fwd_data,
  input  logic               fwd_ld0,
  input  logic               wb_we,
  input  logic [AW-1:0]      wb_rd,
  input  logic [DW-1:0]      wb_data,
  input  logic               hold_in,
  input  logic               flush,
  output logic               stall_out,
  output logic [DW-1:0]      alu_a,
  output logic [DW-1:0]      alu_b,
  output logic [DW-1:0]      store_data,
  output logic [31:0]        instr_out,
  output logic [CW-1:0]      ctrl_out,
  output logic [AW-1:0]      rd_out,
  output logic               valid_out,
  output logic               zero
);

  localparam logic [AW-1:0] XZR = AW'(NREG - 1);

  logic [AW-1:0] rn, rm, rd, fwd_rd0;
  logic [DW-1:0] rf_a, rf_b, imm;
  logic [DW-1:0] alu_a_d, alu_b_d, store_d, reg_b;
  logic          rm_used;

  logic [DW-1:0] alu_a_q, alu_b_q, store_q;
  logic [31:0]   instr_q;
  logic [CW-1:0] ctrl_q;
  logic [AW-1:0] rd_q;
  logic          valid_q, zero_q;

  regdec_regfile #(.DW(DW), .NREG(NREG), .AW(AW)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_we),
    .waddr   (wb_rd),
    .wdata   (wb_data),
    .raddr_a (rn),
    .raddr_b (rm),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

  // Zero register first, then forwarding sources youngest-first, then the
  // same-cycle writeback, and only then the stored register value.
  function automatic logic [DW-1:0] resolve(input logic [AW-1:0] r, input logic [DW-1:0] rf_val);
    logic [DW-1:0] v;
    logic          hit;
    v   = rf_val;
    hit = 1'b0;
    if (r == XZR) begin
      v   = '0;
      hit = 1'b1;
    end
    for (int k = 0; k < NFWD; k++) begin
      if (!hit && fwd_we[k] && (fwd_rd[k*AW +: AW] == r)) begin
        v   = fwd_data[k*DW +: DW];
        hit = 1'b1;
      end
    end
    if (!hit && wb_we && (wb_rd == r)) v = wb_data;
    return v;
  endfunction

  always_comb begin
    rn      = AW'(instr_in[RN_MSB:RN_LSB]);
    rm      = reg2loc ? AW'(instr_in[RM_MSB:RM_LSB]) : AW'(instr_in[RT_MSB:RT_LSB]);
    rd      = AW'(instr_in[RT_MSB:RT_LSB]);
    fwd_rd0 = fwd_rd[AW-1:0];
  end

  always_comb begin
    case (alusrc_t'(alusrc))
      SRC_DADDR9: imm = DW'($signed(instr_in[D9_MSB:D9_LSB]));
      SRC_IMM12:  imm = DW'(instr_in[I12_MSB:I12_LSB]);
      SRC_IMM16:  imm = DW'(instr_in[I16_MSB:I16_LSB]);
      default:    imm = '0;
    endcase
  end

  always_comb begin
    alu_a_d = resolve(rn, rf_a);
    store_d = resolve(rm, rf_b);
    reg_b   = resolve(rm, rf_b);
    alu_b_d = (alusrc_t'(alusrc) == SRC_REG) ? reg_b : imm;
  end

  // The second index only matters for a hazard when it feeds B or is a store source.
  always_comb begin
    rm_used   = (alusrc_t'(alusrc) == SRC_REG) || !reg2loc;
    stall_out = reset && valid_in && fwd_we[0] && fwd_ld0 && (fwd_rd0 != XZR) &&
                ((fwd_rd0 == rn) || ((fwd_rd0 == rm) && rm_used)) &&
                !flush && !hold_in;
  end

  always_ff @(posedge clk) begin
    if (!reset || (!hold_in && (flush || stall_out))) begin
      alu_a_q <= '0;
      alu_b_q <= '0;
      store_q <= '0;
      instr_q <= '0;
      ctrl_q  <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (!hold_in) begin
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      store_q <= store_d;
      instr_q <= instr_in;
      ctrl_q  <= ctrl_in;
      rd_q    <= rd;
      valid_q <= valid_in;
      zero_q  <= ~|alu_b_d;
    end
  end

  always_comb begin
    alu_a      = alu_a_q;
    alu_b      = alu_b_q;
    store_data = store_q;
    instr_out  = instr_q;
    ctrl_out   = ctrl_q;
    rd_out     = rd_q;
    valid_out  = valid_q;
    zero       = zero_q;
  end

endmodule

// File: tb/tb_regdec_stage.sv
// Randomised and directed bench for regdec_stage against a behavioural model of
// the register file, forwarding priority, hazard rule and output register.
module tb_regdec_stage;

  localparam int DW   = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NFWD = 2;
  localparam int CW   = 15;

  logic               clk = 1'b0;
  logic               reset;
  logic [31:0]        instr_in;
  logic               valid_in;
  logic [CW-1:0]      ctrl_in;
  logic               reg2loc;
  logic [1:0]         alusrc;
  logic [NFWD-1:0]    fwd_we;
  logic [NFWD*AW-1:0] fwd_rd;
  logic [NFWD*DW-1:0] fwd_data;
  logic               fwd_ld0;
  logic               wb_we;
  logic [AW-1:0]      wb_rd;
  logic [DW-1:0]      wb_data;
  logic               hold_in;
  logic               flush;
  logic               stall_out;
  logic [DW-1:0]      alu_a, alu_b, store_data;
  logic [31:0]        instr_out;
  logic [CW-1:0]      ctrl_out;
  logic [AW-1:0]      rd_out;
  logic               valid_out;
  logic               zero;

  int vecCount  = 0;
  int missCount = 0;

  logic [DW-1:0] mdlReg [NREG];
  logic [DW-1:0] expA, expB, expStore;
  logic [31:0]   expInstr;
  logic [CW-1:0] expCtrl;
  logic [AW-1:0] expRd;
  logic          expValid, expZero;

  regdec_stage #(.DW(DW), .NREG(NREG), .AW(AW), .NFWD(NFWD), .CW(CW)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .valid_in(valid_in), .ctrl_in(ctrl_in),
    .reg2loc(reg2loc), .alusrc(alusrc), .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .fwd_ld0(fwd_ld0), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .hold_in(hold_in),
    .flush(flush), .stall_out(stall_out), .alu_a(alu_a), .alu_b(alu_b), .store_data(store_data),
    .instr_out(instr_out), .ctrl_out(ctrl_out), .rd_out(rd_out), .valid_out(valid_out), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] readRef(input int r);
    if (r == NREG - 1) return '0;
    for (int k = 0; k < NFWD; k++)
      if (fwd_we[k] && int'(fwd_rd[k*AW +: AW]) == r) return fwd_data[k*DW +: DW];
    if (wb_we && int'(wb_rd) == r) return wb_data;
    return mdlReg[r];
  endfunction

  // Computes the expected stall now and the expected outputs after the next edge.
  task automatic modelStep(output logic expStall);
    int rn, rm, ld, imm;
    logic [DW-1:0] b;
    rn = int'(instr_in[9:5]);
    rm = reg2loc ? int'(instr_in[20:16]) : int'(instr_in[4:0]);
    ld = int'(fwd_rd[AW-1:0]);
    if (!reset) begin
      expStall = 1'b0;
      {expA, expB, expStore, expInstr, expCtrl, expRd, expValid, expZero} = '0;
      for (int i = 0; i < NREG; i++) mdlReg[i] = '0;
      return;
    end
    expStall = valid_in && fwd_we[0] && fwd_ld0 && ld != NREG - 1 &&
               (ld == rn || (ld == rm && (alusrc == 2'b00 || !reg2loc))) && !flush && !hold_in;
    case (alusrc)
      2'b00: b = readRef(rm);
      2'b01: begin
        imm = int'(instr_in[20:12]);
        if (imm >= 256) imm -= 512;
        b = 64'(longint'(imm));
      end
      2'b10: b = 64'(instr_in[21:10]);
      default: b = 64'(instr_in[20:5]);
    endcase
    if (hold_in) begin
    end else if (flush || expStall) begin
      {expA, expB, expStore, expInstr, expCtrl, expRd, expValid, expZero} = '0;
    end else begin
      expA     = readRef(rn);
      expB     = b;
      expStore = readRef(rm);
      expInstr = instr_in;
      expCtrl  = ctrl_in;
      expRd    = instr_in[4:0];
      expValid = valid_in;
      expZero  = (b == 0);
    end
    if (wb_we && int'(wb_rd) != NREG - 1) mdlReg[wb_rd] = wb_data;
  endtask

  task automatic checkOutput();
    cmp("alu_a", alu_a, expA);
    cmp("alu_b", alu_b, expB);
    cmp("store_data", store_data, expStore);
    cmp("instr_out", 64'(instr_out), 64'(expInstr));
    cmp("ctrl_out", 64'(ctrl_out), 64'(expCtrl));
    cmp("rd_out", 64'(rd_out), 64'(expRd));
    cmp("valid_out", 64'(valid_out), 64'(expValid));
    cmp("zero", 64'(zero), 64'(expZero));
  endtask

  task automatic stepCycle();
    logic es;
    @(negedge clk);
    modelStep(es);
    cmp("stall_out", 64'(stall_out), 64'(es));
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle();
    valid_in = 1'b0; instr_in = '0; ctrl_in = '0; reg2loc = 1'b1; alusrc = 2'b00;
    fwd_we = '0; fwd_rd = '0; fwd_data = '0; fwd_ld0 = 1'b0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; hold_in = 1'b0; flush = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input logic [CW-1:0] ctl,
                               input logic r2l, input logic [1:0] src);
    instr_in = ins; valid_in = 1'b1; ctrl_in = ctl; reg2loc = r2l; alusrc = src;
  endtask

  function automatic logic [AW-1:0] pickReg();
    int p = $urandom_range(0, 5);
    return (p == 5) ? AW'(NREG - 1) : AW'(p);
  endfunction

  initial begin
    idle();
    reset = 1'b0;
    stepCycle();
    stepCycle();
    cmp("reset_valid", 64'(valid_out), 64'd0);
    reset = 1'b1;

    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 64'd15;
    stepCycle();
    wb_rd = 5'd1; wb_data = 64'd23;
    stepCycle();
    wb_we = 1'b0;

    applyStimulus(32'hAB010005, 15'h1234, 1'b1, 2'b00);
    stepCycle();
    cmp("adds_a", alu_a, 64'd15);
    cmp("adds_b", alu_b, 64'd23);
    cmp("adds_zero", 64'(zero), 64'd0);
    cmp("adds_rd", 64'(rd_out), 64'd5);

    fwd_we = 2'b11; fwd_rd = {5'd1, 5'd0}; fwd_data = {64'd99, 64'd7};
    stepCycle();
    cmp("fwd_a", alu_a, 64'd7);
    cmp("fwd_b", alu_b, 64'd99);
    fwd_rd = {5'd0, 5'd0};
    stepCycle();
    cmp("fwd_prio_a", alu_a, 64'd7);
    cmp("fwd_prio_b", alu_b, 64'd23);
    fwd_we = '0;

    applyStimulus(32'hFFFFFFFF, 15'h0001, 1'b1, 2'b01);
    stepCycle();
    cmp("imm_d9", alu_b, 64'hFFFFFFFFFFFFFFFF);
    cmp("imm_d9_store", store_data, 64'd0);
    alusrc = 2'b10;
    stepCycle();
    cmp("imm_12", alu_b, 64'h0000000000000FFF);
    alusrc = 2'b11;
    stepCycle();
    cmp("imm_16", alu_b, 64'h000000000000FFFF);

    applyStimulus(32'hAB010005, 15'h0155, 1'b1, 2'b00);
    fwd_we = 2'b01; fwd_rd = {5'd0, 5'd1}; fwd_data = {64'd0, 64'd77}; fwd_ld0 = 1'b1;
    stepCycle();
    cmp("lu_stall", 64'(stall_out), 64'd1);
    cmp("lu_bubble_valid", 64'(valid_out), 64'd0);
    cmp("lu_bubble_ctrl", 64'(ctrl_out), 64'd0);
    fwd_we = 2'b10; fwd_rd = {5'd1, 5'd0}; fwd_data = {64'd42, 64'd0}; fwd_ld0 = 1'b0;
    stepCycle();
    cmp("lu_b", alu_b, 64'd42);
    cmp("lu_valid", 64'(valid_out), 64'd1);

    applyStimulus(32'h8B1F03E3, 15'h0002, 1'b1, 2'b00);
    wb_we = 1'b1; wb_rd = 5'd31; wb_data = 64'd55;
    fwd_we = 2'b01; fwd_rd = {5'd0, 5'd31}; fwd_ld0 = 1'b1;
    stepCycle();
    cmp("xzr_stall", 64'(stall_out), 64'd0);
    cmp("xzr_a", alu_a, 64'd0);
    cmp("xzr_zero", 64'(zero), 64'd1);
    idle();

    applyStimulus(32'hAB010005, 15'h0333, 1'b1, 2'b00);
    stepCycle();
    hold_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h8B1F03E3 ^ 32'(i), 15'h0444, 1'b1, 2'b00);
      stepCycle();
      cmp("hold_a", alu_a, 64'd15);
      cmp("hold_ctrl", 64'(ctrl_out), 64'h333);
    end
    hold_in = 1'b0; flush = 1'b1;
    stepCycle();
    cmp("flush_valid", 64'(valid_out), 64'd0);
    flush = 1'b0;
    applyStimulus(32'hAB010005, 15'h0555, 1'b1, 2'b00);
    stepCycle();
    hold_in = 1'b1; reset = 1'b0;
    stepCycle();
    cmp("rst_hold_valid", 64'(valid_out), 64'd0);
    cmp("rst_hold_a", alu_a, 64'd0);
    reset = 1'b1; hold_in = 1'b0;
    stepCycle();
    cmp("post_rst_x0", alu_a, 64'd0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[9:5] = pickReg(); ins[20:16] = pickReg(); ins[4:0] = pickReg();
      instr_in = ins;
      valid_in = ($urandom_range(0, 7) != 0);
      ctrl_in  = CW'($urandom);
      reg2loc  = 1'($urandom);
      alusrc   = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
      fwd_we   = 2'($urandom);
      fwd_rd   = {pickReg(), pickReg()};
      fwd_data = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
      fwd_ld0  = 1'($urandom);
      wb_we    = 1'($urandom);
      wb_rd    = pickReg();
      wb_data  = ($urandom_range(0, 9) == 0) ? 64'd0 : {32'($urandom), 32'($urandom)};
      hold_in  = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      reset    = ($urandom_range(0, 39) != 0);
      stepCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/regdec_stage.md
# regdec_stage

Parametrised register-read/decode pipeline stage between instruction fetch and execute. Reads two operands from an internal register file, selects the B-operand source (register or one of three immediates), resolves forwarding internally by register-number compare against execute, memory and writeback results, detects load-use hazards and stalls, and registers all operands and control into the execute stage. Successor to the fixed 64-bit, externally-steered decode stage: forwarding, hazard detection, flush and hold now live inside the block.

## Interface
- `DW`, 64, datapath width (≥16)
- `NREG`, 32, architectural registers; index `NREG-1` is the zero register (XZR)
- `AW`, `$clog2(NREG)`, register index width (derived)
- `NFWD`, 2, forwarding sources; index 0 = youngest (execute), ascending = older
- `CW`, 15, width of pass-through control bundle

- `clk` in 1 — clock; all state updates on rising edge
- `reset` in 1 — synchronous, active-low
- `instr_in` in 32 — fetched instruction
- `valid_in` in 1 — `instr_in` carries a real instruction
- `ctrl_in` in CW — decoded control for this instruction, passed through
- `reg2loc` in 1 — 1: second read index = `instr_in[20:16]` (Rm); 0: `instr_in[4:0]` (Rt)
- `alusrc` in 2 — B source: 00 reg, 01 SE `instr[20:12]`, 10 ZE `instr[21:10]`, 11 ZE `instr[20:5]`
- `fwd_we` in NFWD — source k writes a register
- `fwd_rd` in NFWD×AW — destination of source k
- `fwd_data` in NFWD×DW — result of source k
- `fwd_ld0` in 1 — source 0 is a load (data not yet valid)
- `wb_we`, `wb_rd` (AW), `wb_data` (DW) in — register-file write port
- `hold_in` in 1 — downstream stall; freeze output registers
- `flush` in 1 — kill the instruction currently in this stage
- `stall_out` out 1 — combinational; upstream must hold `instr_in`/`ctrl_in`
- `alu_a`, `alu_b`, `store_data` out DW — registered operands
- `instr_out` out 32, `ctrl_out` out CW, `rd_out` out AW, `valid_out` out 1 — registered
- `zero` out 1 — registered; 1 when the forwarded B operand was all zero

## Operation
- Read indices: `rn = instr_in[9:5]`, `rm` per `reg2loc`; upper bits zero-extended/truncated to AW.
- Operand resolve per read index r (A and register-B/store independently), first match wins: r==`NREG-1` → 0; `fwd_we[k] && fwd_rd[k]==r`, k ascending; `wb_we && wb_rd==r` → `wb_data`; register file.
- `alu_b` = resolved Rm/Rt if `alusrc==00`, else the immediate (immediates never forwarded). `store_data` always resolved Rm/Rt. `zero` = NOR of next `alu_b`.
- Register file: `NREG-1` entries, written at clock edge when `wb_we` and `wb_rd != NREG-1`; writes to XZR discarded.
- Hazard: `stall_out = valid_in && fwd_we[0] && fwd_ld0 && fwd_rd[0]!=NREG-1 && (fwd_rd[0]==rn || (fwd_rd[0]==rm && (alusrc==00 || reg2loc==0)))`, forced 0 when `flush` or `hold_in`.
- Output register update priority: `reset` low → all outputs 0; `hold_in` → hold all; `flush` or `stall_out` → bubble (`valid_out=0`, `ctrl_out=0`, datapath outputs don't-care, driven 0); else capture (`valid_out=valid_in`).
- `wb_*` write proceeds under hold/flush/stall.

## Timing
- Latency 1: inputs at edge n appear on outputs after edge n.
- Load-use: exactly one bubble; next cycle source 0 no longer matches, source 1 forwards load data.
- Reset: output registers and register file cleared on the first edge with `reset` low; `stall_out` is 0 during reset.
- Reset mid-stall or mid-hold: reset wins; stall state is not remembered (hazard is re-evaluated combinationally).
- Same-cycle write and read of same register: read returns `wb_data`.

## Structure
- Package `regdec_pkg`: `alusrc_t` enum (`SRC_REG`, `SRC_DADDR9`, `SRC_IMM12`, `SRC_IMM16`), instruction field bit-position constants.
- Sub-module `regdec_regfile` (parametrised DW/NREG, one write, two combinational reads, XZR handling, synchronous active-low clear). Forward resolve as a function reused for three read ports.

## Test plan
- Write X0=15, X1=23 via wb; ADDS X5,X0,X1 (`0xAB010005`, reg2loc=1, alusrc=00) → alu_a=15, alu_b=23, zero=0.
- Same instruction with fwd_we=2'b11, fwd_rd={1,0}, fwd_data={99,7}? Source 0 rd=0 data 7, source 1 rd=0 data 99 → alu_a=7 (priority); source 1 rd=1 → alu_b=99.
- alusrc 01/10/11 with `instr_in=0xFFFFFFFF`, DW=64 → alu_b=`0xFFFFFFFFFFFFFFFF`, `0xFFF`, `0xFFFF`; store_data still register value.
- fwd_ld0=1, fwd_rd[0]=1, reading X1 → stall_out=1, next valid_out=0, ctrl_out=0; next cycle (source 1 = 42) → alu_b=42, valid_out=1.
- Read XZR (index 31) after wb write 55 to 31 and fwd_rd[0]=31 → alu_a=0, zero=1 when B also XZR, no stall.
- hold_in=1 for 3 cycles then flush=1 → outputs frozen, then valid_out=0; reset low mid-hold → all outputs 0, X0 reads 0 after.
